// File: rtl/serial_feeder.sv
// serial_feeder: parallel-to-serial stage feeding the sequence-analysis FSM.
// A WIDTH-bit word is accepted through valid/ready and shifted out on ent,
// one bit per clock. An idle gap of GAP cycles (ent=0) follows every word.
module serial_feeder #(
    parameter int WIDTH     = 8,
    parameter int GAP       = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_valid,
    input  logic [WIDTH-1:0]         load_data,
    output logic                     load_ready,
    output logic                     ent,
    output logic                     ent_valid,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(WIDTH)-1:0] bit_idx
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic               ent_q, ent_d;
    logic               ent_valid_q, ent_valid_d;
    logic               done_q, done_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

    logic               accept;
    logic               load_first;
    logic [WIDTH-1:0]   load_rest;
    logic               next_bit;
    logic [WIDTH-1:0]   next_rest;

    // Bit ordering: the shift register holds the bits not yet sent, with the next one at the exit end.
    always_comb begin
        if (MSB_FIRST) begin
            load_first = load_data[WIDTH-1];
            load_rest  = load_data << 1;
            next_bit   = shift_q[WIDTH-1];
            next_rest  = shift_q << 1;
        end else begin
            load_first = load_data[0];
            load_rest  = load_data >> 1;
            next_bit   = shift_q[0];
            next_rest  = shift_q >> 1;
        end
    end

    // Ready in IDLE, or on the last bit when there is no gap so words can run back-to-back.
    always_comb begin
        load_ready = (state_q == ST_IDLE) ||
                     ((state_q == ST_SHIFT) && (bit_idx_q == LAST_IDX) && (GAP == 0));
        accept     = load_valid && load_ready;
        busy       = (state_q != ST_IDLE);
    end

    // Next-state logic: load, shift, end-of-word handling and gap countdown.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        ent_d       = ent_q;
        ent_valid_d = ent_valid_q;
        done_d      = 1'b0;
        bit_idx_d   = bit_idx_q;
        gap_cnt_d   = gap_cnt_q;

        case (state_q)
            ST_IDLE: begin
                ent_d       = 1'b0;
                ent_valid_d = 1'b0;
                bit_idx_d   = '0;
                if (accept) begin
                    shift_d     = load_rest;
                    ent_d       = load_first;
                    ent_valid_d = 1'b1;
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_idx_q != LAST_IDX) begin
                    ent_d     = next_bit;
                    shift_d   = next_rest;
                    bit_idx_d = bit_idx_q + 1'b1;
                end else begin
                    done_d = 1'b1;
                    if (GAP > 0) begin
                        ent_d       = 1'b0;
                        ent_valid_d = 1'b0;
                        bit_idx_d   = '0;
                        gap_cnt_d   = GAP_LOAD;
                        state_d     = ST_GAP;
                    end else if (accept) begin
                        shift_d     = load_rest;
                        ent_d       = load_first;
                        ent_valid_d = 1'b1;
                        bit_idx_d   = '0;
                    end else begin
                        ent_d       = 1'b0;
                        ent_valid_d = 1'b0;
                        bit_idx_d   = '0;
                        state_d     = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                ent_d       = 1'b0;
                ent_valid_d = 1'b0;
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: begin
                ent_d       = 1'b0;
                ent_valid_d = 1'b0;
                bit_idx_d   = '0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any word in flight without a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            ent_q       <= 1'b0;
            ent_valid_q <= 1'b0;
            done_q      <= 1'b0;
            bit_idx_q   <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            ent_q       <= ent_d;
            ent_valid_q <= ent_valid_d;
            done_q      <= done_d;
            bit_idx_q   <= bit_idx_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign ent       = ent_q;
    assign ent_valid = ent_valid_q;
    assign done      = done_q;
    assign bit_idx   = bit_idx_q;

endmodule

// File: doc/serial_feeder.md
Name: serial_feeder

Overview:
- Parallel-to-serial stage directly upstream of the sequence-analysis FSM; its `ent` output drives that FSM's serial `ent` input on the same `clk`.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock.
- Inserts a programmable idle gap (ent forced 0) between words so the downstream FSM sees clean frame boundaries.

Parameters:
- WIDTH, 8, word length in bits (≥2).
- GAP, 2, idle cycles after each word, with ent=0 (0 allowed = back-to-back).
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
- load_valid  in  1  source presents load_data.
- load_data  in  WIDTH  word to serialize; sampled only on an accepting edge.
- load_ready  out  1  block can accept a word this cycle.
- ent  out  1  serial bit to downstream FSM (registered).
- ent_valid  out  1  ent carries a data bit this cycle (registered).
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after the last bit of a word.
- bit_idx  out  $clog2(WIDTH)  index (0-based, in transmit order) of the bit currently on ent.

Behaviour:
- Reset (rst=0, async): state=IDLE, shift reg=0, ent=0, ent_valid=0, done=0, bit_idx=0, gap counter=0. busy=0 and load_ready=1 follow from the state.
- States: IDLE, SHIFT, GAP.
- Accept condition: load_valid & load_ready at a rising edge. There is no buffering. load_valid while load_ready=0 is ignored, and the source must hold the word until it is accepted.
- load_ready is combinational:
  - 1 in IDLE;
  - 1 in SHIFT when bit_idx==WIDTH-1 and GAP==0;
  - 0 otherwise.
- IDLE: ent=0, ent_valid=0. On an accept at edge N:
  - capture load_data;
  - ent <= first bit;
  - ent_valid <= 1, bit_idx <= 0;
  - go to SHIFT.
- SHIFT, bit_idx < WIDTH-1: each edge presents the next bit and increments bit_idx.
- SHIFT, bit_idx == WIDTH-1, at the next edge:
  - done <= 1 for exactly one cycle.
  - With GAP>0: ent <= 0, ent_valid <= 0, gap counter <= GAP-1, go to GAP.
  - With GAP==0 and an accept on this edge: load the new word and present its first bit with bit_idx=0, stay in SHIFT, keep ent_valid=1 (no bubble).
  - With GAP==0 and no accept: go to IDLE.
- GAP: ent=0, ent_valid=0. The counter decrements each edge. At counter==0 the next edge goes to IDLE. GAP cycles are spent in GAP.
- Latency (accept at edge N): bits valid in the cycles after edges N .. N+WIDTH-1; done is high after edge N+WIDTH; load_ready returns after edge N+WIDTH+GAP.
- Bit order:
  - MSB_FIRST=1: transmit order is load_data[WIDTH-1] down to [0].
  - MSB_FIRST=0: transmit order is [0] up to [WIDTH-1].
- Reset mid-word or mid-gap: the word is abandoned, outputs go to reset values immediately, and no done pulse is issued.
- load_data changing while the block is busy has no effect on the word in flight.

Test Plan:
- WIDTH=8, GAP=2, MSB_FIRST=1:
  - Load 0x1E at edge N -> ent = 0,0,0,1,1,1,1,0 with ent_valid=1 and bit_idx 0..7.
  - done=1 for one cycle after edge N+8.
  - busy=1 through edge N+10; load_ready=1 again after edge N+10.
- MSB_FIRST=0: load 0x1E -> ent = 0,1,1,1,1,0,0,0.
- Busy rejection: assert load_valid with 0xFF during SHIFT of 0x1E -> transmitted stream unchanged. 0xFF is accepted only once load_ready=1, then sent as eight 1s.
- GAP=0, back-to-back:
  - Load 0xFF, with load_valid held high and load_data switched to 0x00 at the last bit.
  - Required response: 16 contiguous cycles of ent_valid=1 (eight 1s, then eight 0s).
  - done pulses twice, eight cycles apart.
- Async reset: drop rst to 0 between clock edges while bit_idx=3 -> ent, ent_valid and bit_idx go to 0 without waiting for a clock edge, and no done pulse follows.
  - Release rst, load 0xA5 -> ent = 1,0,1,0,0,1,0,1 normally.
- Downstream hookup: drive the analysis FSM's ent from this block with 0xFF and GAP=2 -> the FSM receives eight 1s followed by two 0s, matching a hand-applied reference stimulus cycle for cycle.
